// File: rtl/data_types_pkg.sv
// Shared datapath types for the out-of-order core: reservation-station tags,
// 32-bit words and the common data bus broadcast.
package data_types;

  localparam int TAG_W        = 5;
  localparam int N_FU_DEFAULT = 4;

  typedef logic [TAG_W-1:0] rs_tag_t;
  typedef logic [31:0]      word32_t;

  // Tag 0 is reserved to mean "nothing on the bus".
  localparam rs_tag_t NO_VAL = '0;

  typedef struct packed {
    rs_tag_t tag;
    word32_t val;
  } cdb_t;

  typedef struct packed {
    rs_tag_t tag;
    word32_t val;
  } fu_result_t;

endpackage

// File: rtl/result_fifo.sv
// Per-source result buffer. The storage array is left unreset, because only the
// pointers and the count decide which entries are valid.
module result_fifo
  import data_types::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       push_i,
  input  logic       pop_i,
  input  fu_result_t din_i,
  output logic       full_o,
  output logic       empty_o,
  output fu_result_t head_o
);
  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] wr_q, rd_q;
  logic [PW:0]   cnt_q, cnt_d;
  fu_result_t    mem_q [DEPTH];
  logic          push_ok, pop_ok;

  assign full_o  = (cnt_q == (PW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_q];
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  always_comb begin
    cnt_d = cnt_q;
    case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + 1'b1;
      if (pop_ok)  rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_q] <= din_i;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// CDB producer: buffers results per functional unit and broadcasts one per cycle,
// choosing among the non-empty buffers in round-robin order.
module cdb_arbiter
  import data_types::*;
#(
  parameter int N_FU       = N_FU_DEFAULT,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic [N_FU-1:0]         fu_valid_i,
  input  rs_tag_t [N_FU-1:0]      fu_tag_i,
  input  word32_t [N_FU-1:0]      fu_val_i,
  output logic [N_FU-1:0]         fu_ready_o,
  output cdb_t                    cdb_o,
  output logic [$clog2(N_FU)-1:0] cdb_src_o
);
  localparam int SRC_W = $clog2(N_FU);

  logic [N_FU-1:0] push, pop, full, empty;
  fu_result_t      head [N_FU];

  logic [SRC_W-1:0] rr_q, rr_d, win, src_q, src_d;
  logic             any;
  int               idx;
  cdb_t             cdb_q, cdb_d;

  for (genvar i = 0; i < N_FU; i++) begin : g_fu
    // Ready comes from the registered count only, so a full buffer stays
    // closed during the cycle it is popped.
    assign fu_ready_o[i] = ~full[i];
    assign push[i]       = fu_valid_i[i] & ~full[i] & (fu_tag_i[i] != NO_VAL);
    assign pop[i]        = any & (win == SRC_W'(i));

    result_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .push_i  (push[i]),
      .pop_i   (pop[i]),
      .din_i   ('{tag: fu_tag_i[i], val: fu_val_i[i]}),
      .full_o  (full[i]),
      .empty_o (empty[i]),
      .head_o  (head[i])
    );
  end

  always_comb begin
    any = 1'b0;
    win = '0;
    idx = 0;
    for (int k = 0; k < N_FU; k++) begin
      idx = (int'(rr_q) + k) % N_FU;
      if (!any && !empty[idx]) begin
        any = 1'b1;
        win = SRC_W'(idx);
      end
    end
  end

  always_comb begin
    cdb_d = '{tag: NO_VAL, val: '0};
    src_d = '0;
    rr_d  = rr_q;
    if (any) begin
      cdb_d = '{tag: head[win].tag, val: head[win].val};
      src_d = win;
      rr_d  = (int'(win) == N_FU - 1) ? '0 : win + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cdb_q <= '{tag: NO_VAL, val: '0};
      src_q <= '0;
      rr_q  <= '0;
    end else begin
      cdb_q <= cdb_d;
      src_q <= src_d;
      rr_q  <= rr_d;
    end
  end

  assign cdb_o     = cdb_q;
  assign cdb_src_o = src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: a queue-per-source reference model predicts each
// broadcast, which is queued and compared one edge later; directed scenarios on top.
module tb_cdb_arbiter;
  import data_types::*;

  localparam int N = 4;
  localparam int D = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    vld, rdy;
  rs_tag_t [N-1:0] tg;
  word32_t [N-1:0] vl;
  cdb_t            cdb;
  logic [1:0]      src;

  cdb_arbiter #(.N_FU(N), .FIFO_DEPTH(D)) dut (
    .clk_i      (clk),
    .reset_i    (rst),
    .fu_valid_i (vld),
    .fu_tag_i   (tg),
    .fu_val_i   (vl),
    .fu_ready_o (rdy),
    .cdb_o      (cdb),
    .cdb_src_o  (src)
  );

  always #5 clk = ~clk;

  typedef struct {
    rs_tag_t tag;
    word32_t val;
    int      src;
  } exp_t;

  int         n_tests = 0;
  int         n_fail  = 0;
  fu_result_t mq [N][$];
  int         mrr = 0;
  exp_t       sb [$];
  rs_tag_t    last_tag;
  int         last_src;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic idle();
    vld = '0;
    tg  = '0;
    vl  = '0;
  endtask

  // Predict this edge from the model, advance the model, then compare after the edge.
  task automatic cyc();
    exp_t       e;
    logic [N-1:0] er, acc;
    int         w;
    bit         found;
    for (int i = 0; i < N; i++) begin
      er[i]  = (mq[i].size() < D);
      acc[i] = vld[i] && er[i] && (tg[i] != NO_VAL);
    end
    chk("ready", 64'(rdy), 64'(er));
    found = 0;
    w     = 0;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (mrr + k) % N;
      if (!found && mq[j].size() > 0) begin
        found = 1;
        w     = j;
      end
    end
    if (found) begin
      e.tag = mq[w][0].tag;
      e.val = mq[w][0].val;
      e.src = w;
      void'(mq[w].pop_front());
      mrr = (w + 1) % N;
    end else begin
      e = '{NO_VAL, 32'd0, 0};
    end
    for (int i = 0; i < N; i++)
      if (acc[i]) mq[i].push_back('{tag: tg[i], val: vl[i]});
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("cdb_tag", 64'(cdb.tag), 64'(e.tag));
    chk("cdb_val", 64'(cdb.val), 64'(e.val));
    chk("cdb_src", 64'(src), 64'(e.src));
    last_tag = cdb.tag;
    last_src = int'(src);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    rs_tag_t got0 [$];
    int      p0, acc_c, bc_c;
    bit      seen, acc0;

    // Reset
    rst = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_tag", 64'(cdb.tag), 64'(NO_VAL));
    chk("rst_val", 64'(cdb.val), 64'd0);
    chk("rst_src", 64'(src), 64'd0);
    chk("rst_ready", 64'(rdy), 64'hF);

    // Single result from source 2
    vld[2] = 1'b1; tg[2] = 5; vl[2] = 32'hDEADBEEF;
    cyc();
    idle();
    cyc();
    chk("single_tag", 64'(last_tag), 64'd5);
    chk("single_val", 64'(cdb.val), 64'hDEADBEEF);
    chk("single_src", 64'(last_src), 64'd2);
    cyc();
    chk("single_idle", 64'(last_tag), 64'(NO_VAL));

    // Bring rr_ptr back to 0 via one broadcast from source 3
    vld[3] = 1'b1; tg[3] = 12; vl[3] = 32'h1234;
    cyc();
    idle();
    cyc();
    cyc();

    // All four push together: broadcast 1,2,3,4 in order
    vld = '1;
    for (int i = 0; i < N; i++) begin
      tg[i] = rs_tag_t'(i + 1);
      vl[i] = 32'(100 + i);
    end
    cyc();
    idle();
    for (int k = 0; k < N; k++) begin
      cyc();
      chk($sformatf("rr_order%0d", k), 64'(last_tag), 64'(k + 1));
    end
    cyc();

    // Backpressure on source 0 while sources 1 and 2 stay busy
    p0 = 0; seen = 0;
    for (int c = 0; c < 30; c++) begin
      idle();
      if (p0 < 4) begin vld[0] = 1'b1; tg[0] = rs_tag_t'(6 + p0); vl[0] = 32'(600 + p0); end
      if (c < 8) begin
        vld[1] = 1'b1; tg[1] = rs_tag_t'(20 + c); vl[1] = 32'(c);
        vld[2] = 1'b1; tg[2] = rs_tag_t'(10 + c); vl[2] = 32'(c);
      end
      acc0 = vld[0] && rdy[0];
      if (vld[0] && !rdy[0]) seen = 1;
      cyc();
      if (acc0) p0++;
      if (last_src == 0 && last_tag != NO_VAL) got0.push_back(last_tag);
    end
    chk("bp_full_seen", 64'(seen), 64'd1);
    chk("bp_count", 64'(got0.size()), 64'd4);
    for (int k = 0; k < 4; k++)
      chk($sformatf("bp_order%0d", k), 64'(k < got0.size() ? got0[k] : NO_VAL), 64'(6 + k));

    // Fairness: source 3 pushes once amid continuous traffic
    idle();
    acc_c = -1; bc_c = -1;
    for (int c = 0; c < 14; c++) begin
      idle();
      vld[0] = 1'b1; tg[0] = rs_tag_t'(10 + c % 8); vl[0] = 32'(c);
      vld[1] = 1'b1; tg[1] = rs_tag_t'(20 + c % 8); vl[1] = 32'(c);
      vld[2] = 1'b1; tg[2] = rs_tag_t'(1 + c % 8);  vl[2] = 32'(c);
      if (c == 2) begin vld[3] = 1'b1; tg[3] = 9; vl[3] = 32'h99; end
      acc0 = vld[3] && rdy[3];
      cyc();
      if (acc0 && acc_c < 0) acc_c = c;
      if (last_src == 3 && last_tag == 9 && bc_c < 0) bc_c = c;
    end
    chk("fair_seen", 64'(bc_c >= 0 && acc_c >= 0), 64'd1);
    chk("fair_lat", 64'(bc_c > acc_c && (bc_c - acc_c) <= N), 64'd1);

    // Drain, then pushes with NO_VAL tag must be ignored
    idle();
    repeat (8) cyc();
    vld[1] = 1'b1; tg[1] = NO_VAL; vl[1] = 32'd123;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("illegal_rdy", 64'(rdy[1]), 64'd1);
      chk("illegal_idle", 64'(last_tag), 64'(NO_VAL));
    end

    // Random traffic against the model
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < N; i++) begin
        vld[i] = 1'($urandom_range(0, 1));
        tg[i]  = rs_tag_t'($urandom_range(0, 31));
        vl[i]  = $urandom;
      end
      cyc();
    end

    // Reset with results buffered: bus clears at once, buffers discarded
    idle();
    repeat (8) cyc();
    vld = '1;
    for (int i = 0; i < N; i++) begin tg[i] = rs_tag_t'(i + 1); vl[i] = 32'(i); end
    cyc();
    for (int i = 0; i < N; i++) tg[i] = rs_tag_t'(i + 5);
    cyc();
    idle();
    chk("pre_rst_busy", 64'(cdb.tag != NO_VAL), 64'd1);
    #3 rst = 1'b1;
    #1;
    chk("rst_async_tag", 64'(cdb.tag), 64'(NO_VAL));
    chk("rst_async_src", 64'(src), 64'd0);
    for (int i = 0; i < N; i++) mq[i].delete();
    mrr = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("rst2_ready", 64'(rdy), 64'hF);
    repeat (3) cyc();
    chk("rst2_idle", 64'(last_tag), 64'(NO_VAL));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
